// File: rtl/ws2812_frame_driver.sv
// WS2812 frame serializer: captures a frame of 24-bit LED words, emits fixed-period
// pulse-width bits (LED 0 first, MSB first), then holds a latch gap. Optional: WS2812_AUTO_REFRESH_EN.
module ws2812_frame_driver #(
    parameter int unsigned NUM_LEDS     = 64,
    parameter int unsigned SYS_FREQ_MHZ = 100,
    parameter int unsigned PERIOD_NS    = 1250,
    parameter int unsigned T0H_NS       = 400,
    parameter int unsigned T1H_NS       = 800,
    parameter int unsigned LATCH_US     = 80
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [24*NUM_LEDS-1:0]   bits,
    input  logic                     frame_valid,
    output logic                     frame_ready,
    output logic                     signal,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned PER_CYC   = PERIOD_NS * SYS_FREQ_MHZ / 1000;
    localparam int unsigned T0_CYC    = T0H_NS * SYS_FREQ_MHZ / 1000;
    localparam int unsigned T1_CYC    = T1H_NS * SYS_FREQ_MHZ / 1000;
    localparam int unsigned LATCH_CYC = LATCH_US * SYS_FREQ_MHZ;
    localparam int unsigned PW        = $clog2(PER_CYC + 1);
    localparam int unsigned LW        = $clog2(LATCH_CYC + 1);
    localparam int unsigned LED_W     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned IW        = $clog2(24 * NUM_LEDS);

    typedef enum logic [2:0] {
        StLatch,
        StIdle,
        StLoad,
        StHigh,
        StLow
    } state_e;

    state_e                  state;
    logic [LW-1:0]           lat_cnt;
    logic [PW-1:0]           per_cnt;
    logic [LED_W-1:0]        led_idx;
    logic [4:0]              bit_idx;
    logic [24*NUM_LEDS-1:0]  shadow;

    logic [IW-1:0]           bit_pos;
    logic                    cur_bit;
    logic [PW-1:0]           high_cyc;
    logic                    last_bit;

    always_comb begin
        bit_pos  = IW'(led_idx) * IW'(24) + IW'(bit_idx);
        cur_bit  = shadow[bit_pos];
        high_cyc = cur_bit ? PW'(T1_CYC) : PW'(T0_CYC);
        last_bit = (led_idx == LED_W'(NUM_LEDS - 1)) && (bit_idx == 5'd0);
    end

    // signal is driven one edge after the counter value it reflects, so HIGH spans
    // per_cnt 0..high_cyc and the final LOW runs one extra count to close the last period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StLatch;
            lat_cnt     <= '0;
            per_cnt     <= '0;
            led_idx     <= '0;
            bit_idx     <= '0;
            shadow      <= '0;
            signal      <= 1'b0;
            frame_ready <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                StLatch: begin
                    signal <= 1'b0;
                    if (lat_cnt == LW'(LATCH_CYC - 1)) begin
                        state       <= StIdle;
                        frame_ready <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                StIdle: begin
                    if (frame_valid && frame_ready) begin
                        shadow      <= bits;
                        state       <= StLoad;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
`ifdef WS2812_AUTO_REFRESH_EN
                    else begin
                        state       <= StLoad;
                        frame_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
`endif
                end
                StLoad: begin
                    led_idx <= '0;
                    bit_idx <= 5'd23;
                    per_cnt <= '0;
                    state   <= StHigh;
                end
                StHigh: begin
                    per_cnt <= per_cnt + PW'(1);
                    if (per_cnt == high_cyc) begin
                        signal <= 1'b0;
                        state  <= StLow;
                    end else begin
                        signal <= 1'b1;
                    end
                end
                StLow: begin
                    if (last_bit && per_cnt == PW'(PER_CYC)) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        lat_cnt    <= '0;
                        state      <= StLatch;
                    end else if (!last_bit && per_cnt == PW'(PER_CYC - 1)) begin
                        per_cnt <= '0;
                        state   <= StHigh;
                        if (bit_idx == 5'd0) begin
                            bit_idx <= 5'd23;
                            led_idx <= led_idx + LED_W'(1);
                        end else begin
                            bit_idx <= bit_idx - 5'd1;
                        end
                    end else begin
                        per_cnt <= per_cnt + PW'(1);
                    end
                end
                default: state <= StLatch;
            endcase
        end
    end

endmodule
